// File: rtl/bootloader_supervisor_pkg.sv
// Shared encodings and derived-constant helpers for the bootloader supervisor.
// Derived widths are computed in the top from its parameters using these functions.
package bootloader_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_HOST = 2'd0,
        ST_CONNECTED = 2'd1,
        ST_HOLDOFF   = 2'd2,
        ST_BOOT      = 2'd3
    } state_e;

    localparam int US_PER_MS = 1000;

    function automatic int calc_div(input int clk_hz);
        return clk_hz / 1000000;
    endfunction

    // CONNECTED breathes twice as fast; never let the divider collapse to zero.
    function automatic int calc_step_div_conn(input int step_us);
        return (step_us / 2 < 1) ? 1 : step_us / 2;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bootloader_supervisor_breathe_pwm.sv
// Breathing status LED: triangle-wave brightness level driving a free-running PWM.
// force_off parks the level at 0 (direction up) and blanks the LED.
module breathe_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic step_tick,
    input  logic force_off,
    output logic led
);

    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                dir_up_q, dir_up_d;
    logic                led_q, led_d;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        level_d   = level_q;
        dir_up_d  = dir_up_q;
        if (force_off) begin
            level_d  = '0;
            dir_up_d = 1'b1;
        end else if (step_tick) begin
            // Reaching an end costs one step of hold while the direction flips.
            if (dir_up_q) begin
                if (level_q == LEVEL_MAX) dir_up_d = 1'b0;
                else                      level_d  = level_q + PWM_BITS'(1);
            end else begin
                if (level_q == '0) dir_up_d = 1'b1;
                else               level_d  = level_q - PWM_BITS'(1);
            end
        end
        led_d = !force_off && (level_q > pwm_cnt_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q   <= '0;
            pwm_cnt_q <= '0;
            dir_up_q  <= 1'b1;
            led_q     <= 1'b0;
        end else begin
            level_q   <= level_d;
            pwm_cnt_q <= pwm_cnt_d;
            dir_up_q  <= dir_up_d;
            led_q     <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/bootloader_supervisor.sv
// Bootloader supervisor: us/ms tick generation, host-presence tracking from SOF,
// boot arbitration with holdoff, and the mode-dependent breathing status LED.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   ST_WAIT_HOST | no host seen yet; slow breathing; optional autonomous boot
//   ST_CONNECTED | SOFs arriving; fast breathing; SOF restarts the ms timer
//   ST_HOLDOFF   | boot decided; counting HOLDOFF_US before asserting boot
//   ST_BOOT      | boot asserted; terminal until reset
module bootloader_supervisor
    import bootloader_supervisor_pkg::*;
#(
    parameter int CLK_HZ     = 48000000,
    parameter int PWM_BITS   = 8,
    parameter int STEP_US    = 1000,
    parameter int TIMEOUT_MS = 1000,
    parameter int TIMEOUT_EN = 1,
    parameter int HOLDOFF_US = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sof_valid,
    input  logic       boot_req,
    output logic       led,
    output logic       boot,
    output logic       host_present,
    output logic [1:0] state
);

    localparam int DIV           = calc_div(CLK_HZ);
    localparam int STEP_DIV_CONN = calc_step_div_conn(STEP_US);
    localparam int PRE_W         = cnt_width(DIV - 1);
    localparam int MSC_W         = cnt_width(US_PER_MS - 1);
    localparam int TMO_W         = cnt_width(TIMEOUT_MS);
    localparam int HO_W          = cnt_width(HOLDOFF_US);
    localparam int STP_W         = cnt_width(STEP_US);

    localparam logic [PRE_W-1:0] PRE_LAST        = PRE_W'(DIV - 1);
    localparam logic [MSC_W-1:0] MSC_LAST        = MSC_W'(US_PER_MS - 1);
    localparam logic [TMO_W-1:0] TMO_MAX         = TMO_W'(TIMEOUT_MS);
    localparam logic [HO_W-1:0]  HO_LAST         = HO_W'(HOLDOFF_US - 1);
    localparam logic [STP_W-1:0] STP_WAIT_RELOAD = STP_W'(STEP_US - 1);
    localparam logic [STP_W-1:0] STP_CONN_RELOAD = STP_W'(STEP_DIV_CONN - 1);

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [MSC_W-1:0] us_in_ms_q, us_in_ms_d;
    logic [TMO_W-1:0] ms_tmr_q, ms_tmr_d, ms_tmr_inc;
    logic [HO_W-1:0]  ho_q, ho_d;
    logic [STP_W-1:0] step_q, step_d;
    logic             boot_q, boot_d;
    logic             host_q, host_d;
    logic             us_tick, ms_tick, step_tick;
    logic             timeout_hit, holdoff_hit, force_off;

    assign us_tick     = (pre_q == PRE_LAST);
    assign ms_tick     = us_tick && (us_in_ms_q == MSC_LAST);
    assign ms_tmr_inc  = (ms_tick && ms_tmr_q != TMO_MAX) ? ms_tmr_q + TMO_W'(1) : ms_tmr_q;
    // Hit is taken on the tick that brings the timer to the limit, not one cycle later.
    assign timeout_hit = (ms_tmr_inc == TMO_MAX);
    assign holdoff_hit = us_tick && (ho_q == HO_LAST);

    always_comb begin
        state_d    = state_q;
        ms_tmr_d   = ms_tmr_inc;
        ho_d       = ho_q;
        pre_d      = us_tick ? '0 : pre_q + PRE_W'(1);
        us_in_ms_d = ms_tick ? '0 : (us_tick ? us_in_ms_q + MSC_W'(1) : us_in_ms_q);

        unique case (state_q)
            ST_WAIT_HOST: begin
                if (boot_req) begin
                    state_d = ST_HOLDOFF;
                end else if (sof_valid) begin
                    state_d  = ST_CONNECTED;
                    ms_tmr_d = '0;
                end else if (TIMEOUT_EN != 0 && timeout_hit) begin
                    state_d = ST_HOLDOFF;
                end
            end
            ST_CONNECTED: begin
                if (boot_req) begin
                    state_d = ST_HOLDOFF;
                end else if (sof_valid) begin
                    ms_tmr_d = '0;
                end else if (timeout_hit) begin
                    if (TIMEOUT_EN != 0) begin
                        state_d = ST_HOLDOFF;
                    end else begin
                        state_d  = ST_WAIT_HOST;
                        ms_tmr_d = '0;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (holdoff_hit)  state_d = ST_BOOT;
                else if (us_tick) ho_d    = ho_q + HO_W'(1);
            end
            ST_BOOT: begin
                state_d = ST_BOOT;
            end
        endcase

        // Restart the microsecond phase so the holdoff is exactly HOLDOFF_US*DIV cycles.
        if (state_d == ST_HOLDOFF && state_q != ST_HOLDOFF) begin
            pre_d = '0;
            ho_d  = '0;
        end

        boot_d = boot_q || (state_d == ST_BOOT);
        host_d = (state_d == ST_CONNECTED);
    end

    always_comb begin
        step_d    = step_q;
        step_tick = 1'b0;
        if (state_q == ST_WAIT_HOST || state_q == ST_CONNECTED) begin
            if (us_tick) begin
                if (step_q == '0) begin
                    step_tick = 1'b1;
                    step_d    = (state_q == ST_CONNECTED) ? STP_CONN_RELOAD : STP_WAIT_RELOAD;
                end else begin
                    step_d = step_q - STP_W'(1);
                end
            end
        end else begin
            step_d = '0;
        end
    end

    assign force_off = (state_d == ST_HOLDOFF) || (state_d == ST_BOOT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_WAIT_HOST;
            pre_q      <= '0;
            us_in_ms_q <= '0;
            ms_tmr_q   <= '0;
            ho_q       <= '0;
            step_q     <= '0;
            boot_q     <= 1'b0;
            host_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            us_in_ms_q <= us_in_ms_d;
            ms_tmr_q   <= ms_tmr_d;
            ho_q       <= ho_d;
            step_q     <= step_d;
            boot_q     <= boot_d;
            host_q     <= host_d;
        end
    end

    breathe_pwm #(
        .PWM_BITS(PWM_BITS)
    ) u_breathe (
        .clk      (clk),
        .reset    (reset),
        .step_tick(step_tick),
        .force_off(force_off),
        .led      (led)
    );

    assign boot         = boot_q;
    assign host_present = host_q;
    assign state        = state_q;

endmodule

// File: tb/tb_bootloader_supervisor.sv
// Directed bench for bootloader_supervisor at CLK_HZ=4 MHz (DIV=4), PWM_BITS=3,
// STEP_US=4, TIMEOUT_MS=2, HOLDOFF_US=3; a second instance runs with TIMEOUT_EN=0.
module tb_bootloader_supervisor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sof_valid = 1'b0, boot_req = 1'b0;
    logic       led, boot, host_present;
    logic [1:0] state;
    logic       sof_nt = 1'b0, breq_nt = 1'b0;
    logic       led_nt, boot_nt, hp_nt;
    logic [1:0] state_nt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    bootloader_supervisor #(
        .CLK_HZ(4000000), .PWM_BITS(3), .STEP_US(4), .TIMEOUT_MS(2),
        .TIMEOUT_EN(1), .HOLDOFF_US(3)
    ) dut (
        .clk(clk), .reset(reset), .sof_valid(sof_valid), .boot_req(boot_req),
        .led(led), .boot(boot), .host_present(host_present), .state(state)
    );

    bootloader_supervisor #(
        .CLK_HZ(4000000), .PWM_BITS(3), .STEP_US(4), .TIMEOUT_MS(2),
        .TIMEOUT_EN(0), .HOLDOFF_US(3)
    ) dut_nt (
        .clk(clk), .reset(reset), .sof_valid(sof_nt), .boot_req(breq_nt),
        .led(led_nt), .boot(boot_nt), .host_present(hp_nt), .state(state_nt)
    );

    // cyc == N at the negedge following the N-th posedge after reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic do_reset();
        reset = 1'b1;
        sof_valid = 1'b0; boot_req = 1'b0; sof_nt = 1'b0; breq_nt = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic goto(input int n);
        int g = 0;
        while (cyc < n && g < 200000) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic pulse_sof();
        sof_valid = 1'b1;
        @(negedge clk);
        sof_valid = 1'b0;
    endtask

    task automatic pulse_breq();
        boot_req = 1'b1;
        @(negedge clk);
        boot_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if (boot !== 1'b0) begin failures++; $display("FAIL reset_boot: got %0d expected 0", boot); end
        checks++;
        if (led !== 1'b0) begin failures++; $display("FAIL reset_led: got %0d expected 0", led); end
        checks++;
        if (host_present !== 1'b0) begin failures++; $display("FAIL reset_host: got %0d expected 0", host_present); end
        reset = 1'b0;
    endtask

    task automatic test_timeout_boot();
        do_reset();
        goto(7999);
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL t1_before_timeout: state %0d expected 0", state); end
        goto(8000);
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL t1_holdoff_entry: state %0d expected 2", state); end
        goto(8011);
        checks++;
        if (boot !== 1'b0) begin failures++; $display("FAIL t1_boot_early: boot %0d expected 0", boot); end
        goto(8012);
        checks++;
        if (boot !== 1'b1 || state !== 2'd3) begin
            failures++; $display("FAIL t1_boot: boot %0d state %0d expected 1 and 3", boot, state);
        end
        checks++;
        if (led !== 1'b0) begin failures++; $display("FAIL t1_led_off: led %0d expected 0", led); end
    endtask

    task automatic test_sof_presence();
        do_reset();
        goto(10);
        pulse_sof();
        checks++;
        if (state !== 2'd1 || host_present !== 1'b1) begin
            failures++; $display("FAIL t2_connect: state %0d host %0d expected 1 and 1", state, host_present);
        end
        for (int i = 1; i <= 3; i++) begin
            goto(10 + 4000 * i - 1);
            checks++;
            if (state !== 2'd1 || boot !== 1'b0) begin
                failures++; $display("FAIL t2_stay_connected_%0d: state %0d boot %0d expected 1 and 0", i, state, boot);
            end
            pulse_sof();
        end
        goto(19999);
        checks++;
        if (state !== 2'd1) begin failures++; $display("FAIL t2_pre_timeout: state %0d expected 1", state); end
        goto(20000);
        checks++;
        if (state !== 2'd2 || host_present !== 1'b0) begin
            failures++; $display("FAIL t2_timeout: state %0d host %0d expected 2 and 0", state, host_present);
        end
        goto(20012);
        checks++;
        if (boot !== 1'b1) begin failures++; $display("FAIL t2_boot: boot %0d expected 1", boot); end
    endtask

    task automatic test_boot_req_override();
        do_reset();
        goto(10);
        pulse_sof();
        goto(50);
        sof_valid = 1'b1; boot_req = 1'b1;
        @(negedge clk);
        sof_valid = 1'b0; boot_req = 1'b0;
        checks++;
        if (state !== 2'd2 || host_present !== 1'b0) begin
            failures++; $display("FAIL t3_override: state %0d host %0d expected 2 and 0", state, host_present);
        end
        goto(55);
        sof_valid = 1'b1; boot_req = 1'b1;
        @(negedge clk);
        sof_valid = 1'b0; boot_req = 1'b0;
        goto(62);
        checks++;
        if (state !== 2'd2 || boot !== 1'b0) begin
            failures++; $display("FAIL t3_holdoff_hold: state %0d boot %0d expected 2 and 0", state, boot);
        end
        goto(63);
        checks++;
        if (state !== 2'd3 || boot !== 1'b1) begin
            failures++; $display("FAIL t3_boot_latency: state %0d boot %0d expected 3 and 1", state, boot);
        end
        goto(70);
        pulse_sof();
        goto(80);
        pulse_breq();
        goto(100);
        checks++;
        if (state !== 2'd3 || boot !== 1'b1) begin
            failures++; $display("FAIL t3_terminal: state %0d boot %0d expected 3 and 1", state, boot);
        end
    endtask

    task automatic test_no_timeout();
        do_reset();
        goto(8000);
        checks++;
        if (state_nt !== 2'd0 || boot_nt !== 1'b0) begin
            failures++; $display("FAIL t4_wait_8k: state %0d boot %0d expected 0 and 0", state_nt, boot_nt);
        end
        goto(16000);
        checks++;
        if (state_nt !== 2'd0 || boot_nt !== 1'b0) begin
            failures++; $display("FAIL t4_wait_16k: state %0d boot %0d expected 0 and 0", state_nt, boot_nt);
        end
        goto(16010);
        sof_nt = 1'b1;
        @(negedge clk);
        sof_nt = 1'b0;
        checks++;
        if (state_nt !== 2'd1 || hp_nt !== 1'b1) begin
            failures++; $display("FAIL t4_connect: state %0d host %0d expected 1 and 1", state_nt, hp_nt);
        end
        goto(23999);
        checks++;
        if (state_nt !== 2'd1) begin failures++; $display("FAIL t4_pre_drop: state %0d expected 1", state_nt); end
        goto(24000);
        checks++;
        if (state_nt !== 2'd0 || hp_nt !== 1'b0 || boot_nt !== 1'b0) begin
            failures++; $display("FAIL t4_drop: state %0d host %0d boot %0d expected 0 0 0", state_nt, hp_nt, boot_nt);
        end
    endtask

    task automatic test_breathing();
        int lvl = 0;
        bit up = 1'b1;
        int cnt;
        int prev, g, t0, t1, t2;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (up) begin
                if (lvl == 7) up = 1'b0; else lvl++;
            end else begin
                if (lvl == 0) up = 1'b1; else lvl--;
            end
            goto(4 + 16 * k);
            checks++;
            if (dut.u_breathe.level_q !== 3'(lvl)) begin
                failures++; $display("FAIL t5_level_start_%0d: got %0d expected %0d", k, dut.u_breathe.level_q, lvl);
            end
            goto(19 + 16 * k);
            checks++;
            if (dut.u_breathe.level_q !== 3'(lvl)) begin
                failures++; $display("FAIL t5_level_end_%0d: got %0d expected %0d", k, dut.u_breathe.level_q, lvl);
            end
        end
        cnt = 0;
        goto(296);
        for (int i = 0; i < 8; i++) begin cnt += int'(led); @(negedge clk); end
        checks++;
        if (cnt != 3) begin failures++; $display("FAIL t5_duty_3: got %0d expected 3", cnt); end
        cnt = 0;
        goto(360);
        for (int i = 0; i < 8; i++) begin cnt += int'(led); @(negedge clk); end
        checks++;
        if (cnt != 7) begin failures++; $display("FAIL t5_duty_7: got %0d expected 7", cnt); end
        goto(400);
        pulse_sof();
        checks++;
        if (state !== 2'd1) begin failures++; $display("FAIL t5_connected: state %0d expected 1", state); end
        prev = int'(dut.u_breathe.level_q); g = 0;
        while (int'(dut.u_breathe.level_q) == prev && g < 40) begin @(negedge clk); g++; end
        t0 = cyc; prev = int'(dut.u_breathe.level_q); g = 0;
        while (int'(dut.u_breathe.level_q) == prev && g < 40) begin @(negedge clk); g++; end
        t1 = cyc; prev = int'(dut.u_breathe.level_q); g = 0;
        while (int'(dut.u_breathe.level_q) == prev && g < 40) begin @(negedge clk); g++; end
        t2 = cyc;
        checks++;
        if (t1 - t0 != 8) begin failures++; $display("FAIL t5_conn_step_a: got %0d cycles expected 8", t1 - t0); end
        checks++;
        if (t2 - t1 != 8) begin failures++; $display("FAIL t5_conn_step_b: got %0d cycles expected 8", t2 - t1); end
    endtask

    task automatic test_async_reset();
        int g;
        do_reset();
        goto(5);
        pulse_breq();
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL t6_holdoff: state %0d expected 2", state); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || boot !== 1'b0 || led !== 1'b0) begin
            failures++; $display("FAIL t6_async_holdoff: state %0d boot %0d led %0d expected 0 0 0", state, boot, led);
        end
        @(negedge clk);
        reset = 1'b0;
        goto(5);
        pulse_breq();
        goto(18);
        checks++;
        if (boot !== 1'b1) begin failures++; $display("FAIL t6_boot: boot %0d expected 1", boot); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || boot !== 1'b0 || led !== 1'b0) begin
            failures++; $display("FAIL t6_async_boot: state %0d boot %0d led %0d expected 0 0 0", state, boot, led);
        end
        @(negedge clk);
        reset = 1'b0;
        g = 0;
        while (led !== 1'b1 && g < 200) begin @(negedge clk); g++; end
        checks++;
        if (led !== 1'b1) begin failures++; $display("FAIL t6_led_on: led %0d expected 1", led); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (led !== 1'b0) begin failures++; $display("FAIL t6_async_led: led %0d expected 0", led); end
        @(negedge clk);
        reset = 1'b0;
        goto(10);
        checks++;
        if (state !== 2'd0 || boot !== 1'b0) begin
            failures++; $display("FAIL t6_resume_idle: state %0d boot %0d expected 0 and 0", state, boot);
        end
        goto(20);
        pulse_breq();
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL t6_resume_holdoff: state %0d expected 2", state); end
        goto(32);
        checks++;
        if (boot !== 1'b0) begin failures++; $display("FAIL t6_resume_early: boot %0d expected 0", boot); end
        goto(33);
        checks++;
        if (boot !== 1'b1) begin failures++; $display("FAIL t6_resume_boot: boot %0d expected 1", boot); end
    endtask

    initial begin
        test_reset();
        test_timeout_boot();
        test_sof_presence();
        test_boot_req_override();
        test_no_timeout();
        test_breathing();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
